// File: rtl/alu_exec_unit.sv
// ALU execute unit: ALUOp/funct decode, single-cycle registered ALU result with flags, PC incrementer.
// Optional feature: define ALU_OVERFLOW_DETECT_EN to register signed overflow for ADD/SUB on OF.
module alu_exec_unit #(
    parameter int WIDTH    = 32,
    parameter int PC_WIDTH = 8,
    parameter int PC_INC   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    operador1,
    input  logic [WIDTH-1:0]    operador2,
    input  logic [5:0]          Func,
    input  logic [2:0]          InOp,
    input  logic [PC_WIDTH-1:0] pc_in,
    output logic [3:0]          outOp,
    output logic [PC_WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0]    resultado,
    output logic                ZF,
    output logic                OF,
    output logic                out_valid
);

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_XOR = 4'b0011;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_NOR = 4'b1100;

    localparam logic [PC_WIDTH-1:0] PC_INC_W = PC_WIDTH'(PC_INC);

    logic [3:0]       w_sel;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic             w_of;

    logic [WIDTH-1:0] r_result;
    logic             r_zf;
    logic             r_of;
    logic             r_valid;

    function automatic logic [3:0] decode_funct(input logic [5:0] funct);
        case (funct)
            6'b100000: decode_funct = SEL_ADD;
            6'b100010: decode_funct = SEL_SUB;
            6'b100100: decode_funct = SEL_AND;
            6'b100101: decode_funct = SEL_OR;
            6'b100110: decode_funct = SEL_XOR;
            6'b100111: decode_funct = SEL_NOR;
            6'b101010: decode_funct = SEL_SLT;
            default:   decode_funct = SEL_ADD;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] alu_compute(input logic [3:0]       sel,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        case (sel)
            SEL_AND: alu_compute = a & b;
            SEL_OR:  alu_compute = a | b;
            SEL_XOR: alu_compute = a ^ b;
            SEL_NOR: alu_compute = ~(a | b);
            SEL_ADD: alu_compute = a + b;
            SEL_SUB: alu_compute = a - b;
            SEL_SLT: alu_compute = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_compute = '0;
        endcase
    endfunction

`ifdef ALU_OVERFLOW_DETECT_EN
    // Overflow when operands (B inverted for SUB) share a sign that the result does not.
    function automatic logic overflow(input logic [3:0]       sel,
                                      input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic [WIDTH-1:0] r);
        case (sel)
            SEL_ADD: overflow = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            SEL_SUB: overflow = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            default: overflow = 1'b0;
        endcase
    endfunction
`endif

    always_comb begin
        w_sel = SEL_ADD;
        case (InOp)
            3'b000:  w_sel = SEL_ADD;
            3'b001:  w_sel = SEL_SUB;
            3'b010:  w_sel = decode_funct(Func);
            3'b011:  w_sel = SEL_AND;
            3'b100:  w_sel = SEL_OR;
            3'b101:  w_sel = SEL_SLT;
            default: w_sel = SEL_ADD;
        endcase
    end

    assign w_result = alu_compute(w_sel, operador1, operador2);
    assign w_zero   = (w_result == '0);

`ifdef ALU_OVERFLOW_DETECT_EN
    assign w_of = overflow(w_sel, operador1, operador2, w_result);
`else
    assign w_of = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
            r_zf     <= 1'b0;
            r_of     <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_result;
                r_zf     <= w_zero;
                r_of     <= w_of;
            end
        end
    end

    assign outOp     = w_sel;
    assign pc_plus   = pc_in + PC_INC_W;
    assign resultado = r_result;
    assign ZF        = r_zf;
    assign OF        = r_of;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results queued at drive time, popped when out_valid is due.
module tb_alu_exec_unit;

    localparam int WIDTH    = 32;
    localparam int PC_WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             zf;
        logic             of;
    } exp_t;

    logic                clk;
    logic                reset;
    logic                in_valid;
    logic [WIDTH-1:0]    operador1;
    logic [WIDTH-1:0]    operador2;
    logic [5:0]          Func;
    logic [2:0]          InOp;
    logic [PC_WIDTH-1:0] pc_in;
    logic [3:0]          outOp;
    logic [PC_WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0]    resultado;
    logic                ZF;
    logic                OF;
    logic                out_valid;

    exp_t sb[$];
    exp_t last_exp;
    int   n_checks;
    int   n_fail;

    alu_exec_unit #(.WIDTH(WIDTH), .PC_WIDTH(PC_WIDTH), .PC_INC(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .operador1 (operador1),
        .operador2 (operador2),
        .Func      (Func),
        .InOp      (InOp),
        .pc_in     (pc_in),
        .outOp     (outOp),
        .pc_plus   (pc_plus),
        .resultado (resultado),
        .ZF        (ZF),
        .OF        (OF),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] m_sel(input logic [2:0] op, input logic [5:0] fn);
        case (op)
            3'd0: return 4'b0010;
            3'd1: return 4'b0110;
            3'd2: begin
                case (fn)
                    6'h20:   return 4'b0010;
                    6'h22:   return 4'b0110;
                    6'h24:   return 4'b0000;
                    6'h25:   return 4'b0001;
                    6'h26:   return 4'b0011;
                    6'h27:   return 4'b1100;
                    6'h2A:   return 4'b0111;
                    default: return 4'b0010;
                endcase
            end
            3'd3: return 4'b0000;
            3'd4: return 4'b0001;
            3'd5: return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic exp_t m_exec(input logic [3:0] s, input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH-1:0] r;
        r = '0;
        case (s)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0011: r = a ^ b;
            4'b1100: r = ~(a | b);
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        e.res = r;
        e.zf  = (r == 32'd0);
        e.of  = 1'b0;
`ifdef ALU_OVERFLOW_DETECT_EN
        if (s == 4'b0010) e.of = (a[31] == b[31]) && (r[31] != a[31]);
        if (s == 4'b0110) e.of = (a[31] != b[31]) && (r[31] != a[31]);
`endif
        return e;
    endfunction

    // Drives one valid operation at negedge; leaves in_valid high so consecutive calls are back-to-back.
    task automatic issue(input logic [2:0] op, input logic [5:0] fn,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input string name);
        exp_t e;
        exp_t got;
        logic [3:0] s;
        @(negedge clk);
        InOp = op; Func = fn; operador1 = a; operador2 = b; in_valid = 1'b1;
        s = m_sel(op, fn);
        #1;
        n_checks++;
        if (outOp !== s) begin
            n_fail++;
            $display("FAIL %s outOp: got %b expected %b", name, outOp, s);
        end
        sb.push_back(m_exec(s, a, b));
        @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            last_exp = e;
            got.res = resultado; got.zf = ZF; got.of = OF;
            if (out_valid !== 1'b1 || got.res !== e.res || got.zf !== e.zf || got.of !== e.of) begin
                n_fail++;
                $display("FAIL %s result: got v=%b r=%h zf=%b of=%b expected v=1 r=%h zf=%b of=%b",
                         name, out_valid, got.res, got.zf, got.of, e.res, e.zf, e.of);
            end
        end
    endtask

    task automatic idle_cycle(input string name);
        @(negedge clk);
        in_valid = 1'b0;
        operador1 = $urandom; operador2 = $urandom;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || resultado !== last_exp.res || ZF !== last_exp.zf || OF !== last_exp.of) begin
            n_fail++;
            $display("FAIL %s hold: got v=%b r=%h zf=%b of=%b expected v=0 r=%h zf=%b of=%b",
                     name, out_valid, resultado, ZF, OF, last_exp.res, last_exp.zf, last_exp.of);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; operador1 = '0; operador2 = '0;
        Func = 6'h22; InOp = 3'b010; pc_in = 8'h10;
        #12;
        n_checks++;
        if (resultado !== '0 || ZF !== 1'b0 || OF !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got r=%h zf=%b of=%b v=%b expected all 0", resultado, ZF, OF, out_valid);
        end
        n_checks++;
        if (outOp !== 4'b0110 || pc_plus !== 8'h14) begin
            n_fail++;
            $display("FAIL reset_comb: got outOp=%b pc_plus=%h expected 0110 14", outOp, pc_plus);
        end
        @(negedge clk);
        reset = 1'b1;
        last_exp.res = '0; last_exp.zf = 1'b0; last_exp.of = 1'b0;
    endtask

    task automatic test_pc();
        logic [7:0] pcs [4] = '{8'h00, 8'hFC, 8'h7E, 8'hFF};
        logic [7:0] exps[4] = '{8'h04, 8'h00, 8'h82, 8'h03};
        for (int i = 0; i < 4; i++) begin
            pc_in = pcs[i];
            #1;
            n_checks++;
            if (pc_plus !== exps[i]) begin
                n_fail++;
                $display("FAIL pc_plus[%0d]: got %h expected %h", i, pc_plus, exps[i]);
            end
        end
    endtask

    task automatic test_directed();
        issue(3'b010, 6'h20, 32'd5, 32'd7, "add_5_7");
        n_checks++;
        if (resultado !== 32'd12) begin
            n_fail++;
            $display("FAIL add_const: got %0d expected 12", resultado);
        end
        issue(3'b001, 6'h00, 32'h10, 32'h10, "sub_zero");
        n_checks++;
        if (resultado !== 32'd0 || ZF !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_zero_const: got r=%h zf=%b expected 0 1", resultado, ZF);
        end
        issue(3'b010, 6'h2A, 32'hFFFF_FFFF, 32'd1, "slt_neg");
        n_checks++;
        if (resultado !== 32'd1) begin
            n_fail++;
            $display("FAIL slt_neg_const: got %h expected 1", resultado);
        end
        issue(3'b010, 6'h2A, 32'd1, 32'hFFFF_FFFF, "slt_pos");
        issue(3'b000, 6'h00, 32'h7FFF_FFFF, 32'd1, "add_ovf");
        n_checks++;
`ifdef ALU_OVERFLOW_DETECT_EN
        if (resultado !== 32'h8000_0000 || OF !== 1'b1) begin
`else
        if (resultado !== 32'h8000_0000 || OF !== 1'b0) begin
`endif
            n_fail++;
            $display("FAIL add_ovf_const: got r=%h of=%b", resultado, OF);
        end
        issue(3'b001, 6'h00, 32'h8000_0000, 32'd1, "sub_ovf");
        issue(3'b010, 6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, "and");
        issue(3'b010, 6'h25, 32'hF000_0001, 32'h0000_1000, "or");
        issue(3'b010, 6'h26, 32'hAAAA_5555, 32'hFFFF_0000, "xor");
        issue(3'b010, 6'h27, 32'h0F0F_0000, 32'h0000_F0F0, "nor");
        issue(3'b010, 6'h3F, 32'd3, 32'd4, "funct_default");
        issue(3'b011, 6'h00, 32'hFF00, 32'h0FF0, "inop_and");
        issue(3'b100, 6'h00, 32'h1, 32'h2, "inop_or");
        issue(3'b101, 6'h00, 32'h5, 32'h9, "inop_slt");
        issue(3'b110, 6'h00, 32'h1, 32'h1, "inop_110");
        issue(3'b111, 6'h00, 32'hFFFF_FFFF, 32'h1, "inop_111_zero");
        idle_cycle("idle_hold");
    endtask

    task automatic test_back_to_back();
        logic [5:0] fns[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h01};
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), fns[$urandom_range(0, 7)],
                  (i % 5 == 0) ? 32'h7FFF_FFFF : 32'($urandom),
                  (i % 7 == 0) ? 32'h8000_0000 : 32'($urandom), "b2b");
        end
        idle_cycle("b2b_tail");
    endtask

    task automatic test_mid_reset();
        issue(3'b000, 6'h00, 32'd100, 32'd23, "pre_reset");
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (resultado !== '0 || ZF !== 1'b0 || OF !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got r=%h zf=%b of=%b v=%b expected all 0", resultado, ZF, OF, out_valid);
        end
        sb.delete();
        last_exp.res = '0; last_exp.zf = 1'b0; last_exp.of = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        idle_cycle("post_release_idle");
        issue(3'b001, 6'h00, 32'd50, 32'd8, "post_release_op");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_pc();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
